rcc_rst_gen: RTL
================

Name: rcc_rst_gen

Overview:
- System reset generator for the RCC. Merges all reset sources into the single system reset request `rst_gen_n`.
- `rst_gen_n` is the `sys_rst_n` that the per-clock-domain reset synchronizers consume and release in each domain.
- Enforces a minimum reset pulse width, drives the NRST pad, and waits for all sources to go quiet before releasing.
- Keeps the reset-source flags (RSR), which survive every reset except power-on.

Parameters:
- RST_STRETCH, 32, number of sys_clk cycles in ASSERT; must be >= 2.
- SETTLE_CYCLES, 4, consecutive quiet cycles required in HOLD before release; must be >= 1.
- CNT_W, 6, counter width; must hold max(RST_STRETCH, SETTLE_CYCLES) - 1.

Ports:
- sys_clk  input  1  block clock (HSI default; runs during reset).
- sys_rst_n  input  1  asynchronous active-low power-on reset; the only reset of this block.
- pin_rst_n_sync  input  1  NRST pad level, already synchronized to sys_clk; active-low.
- sft_rst_req  input  1  software reset request, level.
- iwdg_rst_req  input  1  independent watchdog reset request, level.
- wwdg_rst_req  input  1  window watchdog reset request, level.
- lpwr_rst_req  input  1  illegal low-power-entry reset request, level.
- rmvf  input  1  single-cycle pulse: clear all reset flags.
- rst_gen_n  output  1  system reset request, active-low, registered.
- nrst_out_n  output  1  NRST pad pull-down enable, active-low, registered.
- rst_busy  output  1  high whenever state != IDLE.
- rsr_flags  output  6  [0] POR, [1] PIN, [2] SFT, [3] IWDG, [4] WWDG, [5] LPWR; sticky.

Behaviour:
- All outputs are registered. sys_rst_n is the only reset; rst_gen_n never resets this block.
- Reset values:
  - state = ASSERT, cnt = 0
  - rst_gen_n = 0, nrst_out_n = 0, rst_busy = 1
  - rsr_flags = 6'b000001
- Definitions:
  - req_any = sft | iwdg | wwdg | lpwr
  - quiet = pin_rst_n_sync & ~req_any
- States: IDLE, ASSERT, HOLD.
- ASSERT:
  - rst_gen_n = 0 and nrst_out_n = 0.
  - cnt increments each cycle. When cnt == RST_STRETCH-1, go to HOLD with cnt = 0.
  - Source requests seen in ASSERT OR their flag in but do not restart the count.
  - pin_rst_n_sync low in ASSERT is ignored for flagging: it is the block's own drive.
- HOLD:
  - rst_gen_n = 0; nrst_out_n = 1 (pad released so its feedback can settle).
  - If quiet, cnt increments; if not quiet, cnt clears to 0.
  - When quiet and cnt == SETTLE_CYCLES-1, go to IDLE: rst_gen_n = 1 and rst_busy = 0 on that edge.
  - Source requests in HOLD OR their flag in. The PIN flag is not set in HOLD.
  - A source held active keeps the block in HOLD indefinitely.
- IDLE:
  - rst_gen_n = 1, nrst_out_n = 1.
  - If req_any or ~pin_rst_n_sync is sampled at edge N, then after edge N:
    - state = ASSERT, cnt = 0, rst_gen_n = 0, nrst_out_n = 0.
    - Every active source sets its flag; PIN is set if the pad is low.
  - Latency from request to rst_gen_n low is 1 cycle.
- Minimum rst_gen_n low time is RST_STRETCH + SETTLE_CYCLES cycles.
- rmvf:
  - Honoured only in IDLE; ignored in ASSERT and HOLD.
  - Clears all six flags on the next edge, including POR.
  - If rmvf coincides with a new request, the new source's flag is set and all others are cleared.
- Flags are only set by events and cleared by rmvf or sys_rst_n. POR is set only by sys_rst_n.
- sys_rst_n asserted mid-sequence: immediately returns to the reset values (ASSERT, cnt 0, flags = POR only).
- No combinational path from any input to any output.

Test Plan:
- POR:
  - Stimulus: hold sys_rst_n low 3 cycles, release, all sources idle with pad high.
  - Response: rst_gen_n low for 32 + 4 = 36 cycles after release, then high; rsr_flags = 6'h01; nrst_out_n low for the first 32 cycles only.
- Software reset from IDLE:
  - Stimulus: rmvf pulse (flags become 0), then sft_rst_req high 1 cycle.
  - Response: rst_gen_n low 1 cycle later; released after 36 cycles; rsr_flags = 6'h04.
- Pad feedback:
  - Stimulus: in a software reset, keep pin_rst_n_sync low through ASSERT and for 3 cycles into HOLD.
  - Response: PIN flag not set; release occurs 4 quiet cycles after the pad goes high.
- Stuck source:
  - Stimulus: iwdg_rst_req held high 100 cycles from IDLE.
  - Response: block stays in HOLD (rst_gen_n = 0) until 4 cycles after the request drops; rsr_flags[3] = 1.
- Simultaneous events:
  - Stimulus: in IDLE, rmvf coincides with wwdg_rst_req and lpwr_rst_req while flags = 6'h05.
  - Response: rsr_flags = 6'h30.
- Mid-sequence POR:
  - Stimulus: sys_rst_n pulsed low during HOLD of a PIN reset.
  - Response: flags = 6'h01, cnt restarts, full 36-cycle reset follows.

Source files
------------

// File: rtl/rcc_rst_gen.sv
// rcc_rst_gen: system reset generator for the RCC.
// Merges the pad, software, watchdog and low-power reset sources into one
// registered active-low reset request (rst_gen_n). The request is stretched
// to a minimum width and the NRST pad is driven. Release happens only after
// every source has stayed quiet for a settle window. Sticky reset-cause flags
// are kept, and only power-on (sys_rst_n) or an explicit rmvf clears them.
//
// Parameter constraints, which are not checked at elaboration:
//   RST_STRETCH >= 2, SETTLE_CYCLES >= 1,
//   CNT_W must hold max(RST_STRETCH, SETTLE_CYCLES) - 1.
module rcc_rst_gen #(
    parameter int RST_STRETCH   = 32,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 6
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       pin_rst_n_sync,
    input  logic       sft_rst_req,
    input  logic       iwdg_rst_req,
    input  logic       wwdg_rst_req,
    input  logic       lpwr_rst_req,
    input  logic       rmvf,
    output logic       rst_gen_n,
    output logic       nrst_out_n,
    output logic       rst_busy,
    output logic [5:0] rsr_flags
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    localparam int NUM_FLAGS = 6;
    localparam int FLAG_POR  = 0;
    localparam int FLAG_PIN  = 1;
    localparam int FLAG_SRC0 = 2;   // first of the four request-source flags

    localparam logic [CNT_W-1:0]     STRETCH_LAST = CNT_W'(RST_STRETCH - 1);
    localparam logic [CNT_W-1:0]     SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]     CNT_ONE      = CNT_W'(1);
    localparam logic [NUM_FLAGS-1:0] FLAGS_POR    = NUM_FLAGS'(1) << FLAG_POR;

    // Registered state and outputs
    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 rst_gen_n_q;
    logic                 nrst_out_n_q;
    logic                 rst_busy_q;
    logic [NUM_FLAGS-1:0] flags_q;
    logic [NUM_FLAGS-1:0] flags_d;

    // Decoded request conditions
    logic [3:0]           src_req;
    logic                 req_any;
    logic                 quiet;
    logic                 in_idle;
    logic                 start_req;
    logic                 flag_clr;
    logic [NUM_FLAGS-1:0] flag_evt;

    // Source order matches the flag layout: SFT, IWDG, WWDG, LPWR.
    assign src_req = {lpwr_rst_req, wwdg_rst_req, iwdg_rst_req, sft_rst_req};

    // Combine the sources and decide what this cycle's events are
    always_comb begin
        in_idle   = (state_q == ST_IDLE);
        req_any   = |src_req;
        quiet     = pin_rst_n_sync & ~req_any;
        start_req = in_idle & (req_any | ~pin_rst_n_sync);
        // rmvf is honoured only outside a reset sequence, so it can never
        // erase the cause of a reset that is still in progress.
        flag_clr  = in_idle & rmvf;
        flag_evt  = '0;
        flag_evt[FLAG_SRC0 +: 4] = src_req;
        // Outside IDLE a low pad is the block's own drive, or its slow
        // feedback, so it never counts as an external pin reset.
        flag_evt[FLAG_PIN] = in_idle & ~pin_rst_n_sync;
    end

    // Per-flag next state: either rebuilt from this cycle's events on a
    // clear, or accumulated. POR has no event source and so can only be
    // cleared here.
    generate
        for (genvar gi = 0; gi < NUM_FLAGS; gi++) begin : g_flag
            assign flags_d[gi] = flag_clr ? flag_evt[gi]
                                          : (flags_q[gi] | flag_evt[gi]);
        end
    endgenerate

    // Sticky reset-cause flags; only power-on reset reloads POR
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            flags_q <= FLAGS_POR;
        end else begin
            flags_q <= flags_d;
        end
    end

    // Reset sequencing FSM with registered outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= ST_ASSERT;
            cnt_q        <= '0;
            rst_gen_n_q  <= 1'b0;
            nrst_out_n_q <= 1'b0;
            rst_busy_q   <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_req) begin
                        state_q      <= ST_ASSERT;
                        cnt_q        <= '0;
                        rst_gen_n_q  <= 1'b0;
                        nrst_out_n_q <= 1'b0;
                        rst_busy_q   <= 1'b1;
                    end
                end
                ST_ASSERT: begin
                    // The stretch runs to its end regardless of new requests.
                    // Requests seen here only add their flags.
                    if (cnt_q == STRETCH_LAST) begin
                        state_q      <= ST_HOLD;
                        cnt_q        <= '0;
                        nrst_out_n_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_HOLD: begin
                    // Any activity restarts the settle window. A stuck
                    // source therefore holds the system in reset.
                    if (!quiet) begin
                        cnt_q <= '0;
                    end else if (cnt_q == SETTLE_LAST) begin
                        state_q     <= ST_IDLE;
                        cnt_q       <= '0;
                        rst_gen_n_q <= 1'b1;
                        rst_busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q      <= ST_ASSERT;
                    cnt_q        <= '0;
                    rst_gen_n_q  <= 1'b0;
                    nrst_out_n_q <= 1'b0;
                    rst_busy_q   <= 1'b1;
                end
            endcase
        end
    end

    assign rst_gen_n  = rst_gen_n_q;
    assign nrst_out_n = nrst_out_n_q;
    assign rst_busy   = rst_busy_q;
    assign rsr_flags  = flags_q;

endmodule
